// File: rtl/charmap_fetch.sv
`default_nettype none
// ============================================================================
// Module   : charmap_fetch
// Function : per-cell character/colour/glyph fetch with a registered pixel
//            serialiser. Per-cell colour is fetched only when CHARMAP_COLOUR_EN
//            is defined; otherwise colour is a constant 8'hFF.
// Revision : 1.0 - initial release
// ============================================================================
module charmap_fetch #(
    parameter int COLS    = 40,
    parameter int ROWS    = 30,
    parameter int H_TOTAL = 384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [8:0]  hcnt,
    input  logic [8:0]  vcnt,
    output logic [10:0] chram_addr,
    input  logic [7:0]  chram_q,
    output logic [10:0] colram_addr,
    input  logic [7:0]  colram_q,
    output logic [10:0] chrom_addr,
    input  logic [7:0]  chrom_q,
    output logic        pixel_on,
    output logic [7:0]  pixel_colour
);

    localparam logic [6:0] CELLS_PER_LINE = 7'(H_TOTAL / 8);
    localparam logic [6:0] COLS_W         = 7'(COLS);
    localparam logic [6:0] ROWS_W         = 7'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHAR      = 3'd1,
        S_CHAR_WAIT = 3'd2,
        S_COL_WAIT  = 3'd3,
        S_ROM       = 3'd4,
        S_ROM_WAIT  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  line_lo_q, line_lo_d;
    logic        oob_q, oob_d;
    logic [7:0]  code_q, code_d;
    logic [10:0] chram_addr_q, chram_addr_d;
    logic [10:0] colram_addr_q, colram_addr_d;
    logic [10:0] chrom_addr_q, chrom_addr_d;
    logic [7:0]  next_pattern_q, next_pattern_d;
    logic [7:0]  next_colour_q, next_colour_d;
    logic [7:0]  cur_pattern_q, cur_pattern_d;
    logic [7:0]  cur_colour_q, cur_colour_d;
    logic        pixel_on_q, pixel_on_d;
    logic [7:0]  pixel_colour_q, pixel_colour_d;

    logic [6:0]  tgt_col;
    logic [8:0]  tgt_line;
    logic [10:0] tgt_addr;
    logic        tgt_oob;

`ifndef CHARMAP_COLOUR_EN
    logic unused_colram;
    assign unused_colram = ^colram_q;
`endif

    // The cell fetched now is the one displayed after the current cell ends.
    always_comb begin
        tgt_col  = {1'b0, hcnt[8:3]} + 7'd1;
        tgt_line = vcnt;
        if (tgt_col == CELLS_PER_LINE) begin
            tgt_col  = 7'd0;
            tgt_line = vcnt + 9'd1;
        end
        tgt_addr = 11'(tgt_line[8:3]) * 11'(COLS) + 11'(tgt_col);
        tgt_oob  = (tgt_col >= COLS_W) || ({1'b0, tgt_line[8:3]} >= ROWS_W);
    end

    always_comb begin
        state_d        = state_q;
        line_lo_d      = line_lo_q;
        oob_d          = oob_q;
        code_d         = code_q;
        chram_addr_d   = chram_addr_q;
        colram_addr_d  = colram_addr_q;
        chrom_addr_d   = chrom_addr_q;
        next_pattern_d = next_pattern_q;
        next_colour_d  = next_colour_q;
        cur_pattern_d  = cur_pattern_q;
        cur_colour_d   = cur_colour_q;
        pixel_on_d     = pixel_on_q;
        pixel_colour_d = pixel_colour_q;

        // Address registers load on entry to CHAR/ROM so they sit on the bus
        // during those states and hold afterwards.
        case (state_q)
            S_IDLE: begin
                if (ce_pix && (hcnt[2:0] == 3'd0)) begin
                    state_d      = S_CHAR;
                    line_lo_d    = tgt_line[2:0];
                    oob_d        = tgt_oob;
                    chram_addr_d = tgt_addr;
`ifdef CHARMAP_COLOUR_EN
                    colram_addr_d = tgt_addr;
`endif
                end
            end
            S_CHAR: state_d = S_CHAR_WAIT;
            S_CHAR_WAIT: begin
                code_d  = chram_q;
                state_d = S_COL_WAIT;
            end
            S_COL_WAIT: begin
`ifdef CHARMAP_COLOUR_EN
                next_colour_d = colram_q;
`else
                next_colour_d = 8'hFF;
`endif
                chrom_addr_d = {code_q, line_lo_q};
                state_d      = S_ROM;
            end
            S_ROM: state_d = S_ROM_WAIT;
            S_ROM_WAIT: begin
                next_pattern_d = oob_q ? 8'h00 : chrom_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ce_pix) begin
            pixel_on_d     = cur_pattern_q[3'd7 - hcnt[2:0]];
            pixel_colour_d = cur_colour_q;
            if (hcnt[2:0] == 3'd7) begin
                cur_pattern_d = next_pattern_q;
                cur_colour_d  = next_colour_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            line_lo_q      <= 3'd0;
            oob_q          <= 1'b0;
            code_q         <= 8'd0;
            chram_addr_q   <= 11'd0;
            colram_addr_q  <= 11'd0;
            chrom_addr_q   <= 11'd0;
            next_pattern_q <= 8'd0;
            next_colour_q  <= 8'd0;
            cur_pattern_q  <= 8'd0;
            cur_colour_q   <= 8'd0;
            pixel_on_q     <= 1'b0;
            pixel_colour_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            line_lo_q      <= line_lo_d;
            oob_q          <= oob_d;
            code_q         <= code_d;
            chram_addr_q   <= chram_addr_d;
            colram_addr_q  <= colram_addr_d;
            chrom_addr_q   <= chrom_addr_d;
            next_pattern_q <= next_pattern_d;
            next_colour_q  <= next_colour_d;
            cur_pattern_q  <= cur_pattern_d;
            cur_colour_q   <= cur_colour_d;
            pixel_on_q     <= pixel_on_d;
            pixel_colour_q <= pixel_colour_d;
        end
    end

    assign chram_addr   = chram_addr_q;
    assign colram_addr  = colram_addr_q;
    assign chrom_addr   = chrom_addr_q;
    assign pixel_on     = pixel_on_q;
    assign pixel_colour = pixel_colour_q;

endmodule
`default_nettype wire

// File: doc/charmap_fetch.md
CHARMAP_FETCH -- requirements
Module: charmap_fetch

Interface
REQ-001 Parameter COLS, default 40: character columns shown per line.
REQ-002 Parameter ROWS, default 30: character rows shown per frame.
REQ-003 Parameter H_TOTAL, default 384: pixel clocks per line, including blanking; must be a multiple of 8.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1: synchronous active-low reset.
REQ-006 Port ce_pix, input, 1: pixel clock enable.
REQ-007 Port hcnt, input, 9: current pixel column, 0..H_TOTAL-1.
REQ-008 Port vcnt, input, 9: current line.
REQ-009 Port chram_addr, output, 11: character RAM read address (row*COLS+col), to the RAM read port.
REQ-010 Port chram_q, input, 8: character code; valid 1 clk after chram_addr.
REQ-011 Port colram_addr, output, 11: colour RAM read address.
REQ-012 Port colram_q, input, 8: foreground colour; valid 1 clk after colram_addr.
REQ-013 Port chrom_addr, output, 11: font ROM address {code, line[2:0]}.
REQ-014 Port chrom_q, input, 8: glyph row, MSB = leftmost pixel; valid 1 clk after chrom_addr.
REQ-015 Port pixel_on, output, 1: registered glyph bit for the current pixel.
REQ-016 Port pixel_colour, output, 8: registered colour for the current pixel.

Function
REQ-017 Fetch FSM states: IDLE, CHAR, CHAR_WAIT, COL_WAIT, ROM, ROM_WAIT; one transition per clk, independent of ce_pix.
REQ-018 IDLE->CHAR on a clk where ce_pix=1 and hcnt[2:0]=0; otherwise stay in IDLE.
REQ-019 Target cell: col n=hcnt[8:3]+1, line=vcnt; if n=H_TOTAL/8, then n=0 and line=vcnt+1.
REQ-020 CHAR: drive chram_addr and colram_addr = (line>>3)*COLS+n; ->CHAR_WAIT.
REQ-021 CHAR_WAIT: latch chram_q as code; ->COL_WAIT. COL_WAIT: latch colram_q as colour; ->ROM.
REQ-022 ROM: drive chrom_addr={code,line[2:0]}; ->ROM_WAIT. ROM_WAIT: latch chrom_q into the next-pattern register; ->IDLE.
REQ-023 Out-of-area target (n>=COLS or (line>>3)>=ROWS): still run all states, but latch next pattern 8'h00.
REQ-024 Fetch completes within 6 clk, so it is always finished before the hcnt[2:0]=7 ce_pix, even with ce_pix asserted on every clk.
REQ-025 On each ce_pix: pixel_on <= cur_pattern[7-hcnt[2:0]]; pixel_colour <= cur_colour.
REQ-026 On ce_pix with hcnt[2:0]=7: after the REQ-025 update, cur_pattern <= next pattern and cur_colour <= next colour.
REQ-027 Latency: pixel_on/pixel_colour are valid the clk after the ce_pix at hcnt=h, and represent screen pixel h.
REQ-028 If hcnt jumps mid-cell (e.g. counter reset), complete the fetch already in progress; the next fetch starts only at hcnt[2:0]=0.
REQ-029 Outputs hold their value between ce_pix pulses.
REQ-030 Address outputs hold their last value outside the CHAR and ROM states.

Reset
REQ-031 reset_n=0 at a clk edge sets: FSM=IDLE; every address output=0; pixel_on=0; pixel_colour=0; cur/next pattern=0; cur/next colour=0.
REQ-032 Reset takes priority over ce_pix and aborts any fetch in progress; after release, the first fetch starts at the next qualifying ce_pix.

Configuration
REQ-033 Macro CHARMAP_COLOUR_EN defined: colour is fetched per REQ-020/021 and emitted per cell.
REQ-034 Macro CHARMAP_COLOUR_EN undefined:
- colram_addr is held at 0 and colram_q is ignored.
- COL_WAIT still occupies one clk.
- colour is forced to 8'hFF (pixel_colour=8'h00 while in reset).

Verification
REQ-035 Cell (0,0) code 8'h41, colour 8'h1C, font {0x41,line0}=8'h81; scan line 0 -> pixel_on=1 at hcnt 0 and 7, 0 at hcnt 1-6; pixel_colour=8'h1C.
REQ-036 ce_pix every clk vs ce_pix every 4th clk, same RAM contents -> identical pixel_on/pixel_colour sequence per hcnt.
REQ-037 hcnt=H_TOTAL-8, vcnt=7 -> chram_addr=COLS (row 1, col 0), chrom_addr line bits=0.
REQ-038 Column COLS and row ROWS, with RAM filled 8'hFF -> pixel_on=0 outside the active area.
REQ-039 reset_n=0 for 1 clk while FSM is in ROM_WAIT -> next clk FSM=IDLE, pixel_on=0, pixel_colour=0.
REQ-040 Build without CHARMAP_COLOUR_EN, colram_q toggling -> colram_addr=0 always and pixel_colour=8'hFF after the first load.
